// File: rtl/serial_bus_pkg.sv
// ============================================================================
// Module   : serial_bus_pkg
// Brief    : Shared types, state encoding and index helpers for the bus scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_bus_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      BUSY    = 3'd2,
      RELEASE = 3'd3
   } bus_state_t;

   // Raw encodings for blocks that observe bus_state without importing the enum.
   localparam logic [2:0] c_bus_idle    = 3'd0;
   localparam logic [2:0] c_bus_grant   = 3'd1;
   localparam logic [2:0] c_bus_busy    = 3'd2;
   localparam logic [2:0] c_bus_release = 3'd3;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // base + off wrapped into 0..n-1; base is always already below n.
   function automatic int rr_index(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bus_scheduler_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first valid requester at or after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import serial_bus_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      winner = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && valid[rr_index(int'(ptr), i, N)]) begin
            winner[rr_index(int'(ptr), i, N)] = 1'b1;
            idx = IDX_W'(rr_index(int'(ptr), i, N));
            any = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_bus_scheduler.sv
// ============================================================================
// Module   : serial_bus_scheduler
// Brief    : Round-robin bus grant FSM with latched selects and ready watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_bus_scheduler
   import serial_bus_pkg::*;
#(
   parameter int NO_MASTERS = 2,
   parameter int NO_SLAVES  = 3,
   parameter int SID_W      = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                              clk,
   input  logic                              rstN,
   input  logic [NO_MASTERS-1:0]             req,
   input  logic [NO_MASTERS*SID_W-1:0]       slave_id,
   input  logic [NO_MASTERS-1:0]             done,
   input  logic                              ready,
   output logic [NO_MASTERS-1:0]             grant,
   output logic [idx_w(NO_MASTERS)-1:0]      master_sel,
   output logic [SID_W-1:0]                  slave_sel,
   output logic [NO_MASTERS-1:0]             reject,
   output logic                              timeout_err,
   output logic [2:0]                        bus_state
);

   localparam int             c_ms_w    = idx_w(NO_MASTERS);
   localparam int             c_wd_w    = idx_w(TIMEOUT);
   localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

   logic [NO_MASTERS-1:0] w_valid;
   logic [NO_MASTERS-1:0] w_invalid;
   logic [NO_MASTERS-1:0] w_win;
   logic [c_ms_w-1:0]     w_idx;
   logic                  w_any;
   logic [SID_W-1:0]      w_win_sid;

   bus_state_t            r_state;
   logic [NO_MASTERS-1:0] r_grant;
   logic [c_ms_w-1:0]     r_master_sel;
   logic [c_ms_w-1:0]     r_owner;
   logic [c_ms_w-1:0]     r_ptr;
   logic [SID_W-1:0]      r_slave_sel;
   logic [NO_MASTERS-1:0] r_reject;
   logic                  r_timeout_err;
   logic [c_wd_w-1:0]     r_wd;

   for (genvar m = 0; m < NO_MASTERS; m++) begin : g_valid
      logic w_id_ok;
      assign w_id_ok      = 32'(slave_id[m*SID_W +: SID_W]) < NO_SLAVES;
      assign w_valid[m]   = req[m] & w_id_ok;
      assign w_invalid[m] = req[m] & ~w_id_ok;
   end

   rr_pick #(
      .N     (NO_MASTERS),
      .IDX_W (c_ms_w)
   ) u_rr_pick (
      .valid  (w_valid),
      .ptr    (r_ptr),
      .winner (w_win),
      .idx    (w_idx),
      .any    (w_any)
   );

   assign w_win_sid = slave_id[w_idx*SID_W +: SID_W];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_master_sel  <= '0;
         r_owner       <= '0;
         r_ptr         <= '0;
         r_slave_sel   <= '0;
         r_reject      <= '0;
         r_timeout_err <= 1'b0;
         r_wd          <= '0;
      end else begin
         r_reject      <= '0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               r_reject <= w_invalid;
               if (w_any) begin
                  r_grant      <= w_win;
                  r_master_sel <= w_idx;
                  r_owner      <= w_idx;
                  r_slave_sel  <= w_win_sid;
                  r_state      <= GRANT;
               end
            end
            GRANT: begin
               r_wd    <= '0;
               r_state <= BUSY;
            end
            BUSY: begin
               // A done or an abort takes priority over a coincident watchdog expiry.
               if (done[r_owner] || !req[r_owner]) begin
                  r_grant      <= '0;
                  r_master_sel <= '0;
                  r_slave_sel  <= '0;
                  r_state      <= RELEASE;
               end else if (!ready && r_wd == c_wd_last) begin
                  r_grant       <= '0;
                  r_master_sel  <= '0;
                  r_slave_sel   <= '0;
                  r_timeout_err <= 1'b1;
                  r_state       <= RELEASE;
               end else begin
                  r_wd <= ready ? '0 : r_wd + c_wd_w'(1);
               end
            end
            RELEASE: begin
               r_ptr   <= (32'(r_owner) == NO_MASTERS - 1) ? '0 : r_owner + c_ms_w'(1);
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant       = r_grant;
   assign master_sel  = r_master_sel;
   assign slave_sel   = r_slave_sel;
   assign reject      = r_reject;
   assign timeout_err = r_timeout_err;
   assign bus_state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_serial_bus_scheduler.sv
// ============================================================================
// Module   : tb_serial_bus_scheduler
// Brief    : Self-checking bench: vector table, directed corner cases, random vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_bus_scheduler;

   localparam int NM = 2;
   localparam int NS = 3;
   localparam int SW = 2;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [1:0] req = '0;
   logic [3:0] slave_id = '0;
   logic [1:0] done = '0;
   logic       ready = 1'b1;
   logic [1:0] grant;
   logic       master_sel;
   logic [1:0] slave_sel;
   logic [1:0] reject;
   logic       timeout_err;
   logic [2:0] bus_state;

   serial_bus_scheduler #(
      .NO_MASTERS (NM),
      .NO_SLAVES  (NS),
      .SID_W      (SW),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rstN        (rstN),
      .req         (req),
      .slave_id    (slave_id),
      .done        (done),
      .ready       (ready),
      .grant       (grant),
      .master_sel  (master_sel),
      .slave_sel   (slave_sel),
      .reject      (reject),
      .timeout_err (timeout_err),
      .bus_state   (bus_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner/pointer/ready-low streak, expected outputs as ints.
   int e_state, e_grant, e_msel, e_ssel, e_rej, e_terr;
   int m_owner, m_ptr, m_streak;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         if (n_errors <= 50)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sid_of(input int m);
      return int'((slave_id >> (SW * m)) & 4'h3);
   endfunction

   task automatic model_reset();
      e_state = 0; e_grant = 0; e_msel = 0; e_ssel = 0; e_rej = 0; e_terr = 0;
      m_owner = -1; m_ptr = 0; m_streak = 0;
   endtask

   task automatic model_step();
      int  m;
      bit  rel;
      rel    = 0;
      e_rej  = 0;
      e_terr = 0;
      case (e_state)
         0: begin
            for (int i = 0; i < NM; i++)
               if (req[i] && sid_of(i) >= NS) e_rej = e_rej | (1 << i);
            for (int i = 0; i < NM; i++) begin
               m = (m_ptr + i) % NM;
               if (m_owner < 0 && req[m] && sid_of(m) < NS) m_owner = m;
            end
            if (m_owner >= 0) begin
               e_grant = 1 << m_owner;
               e_msel  = m_owner;
               e_ssel  = sid_of(m_owner);
               e_state = 1;
            end
         end
         1: begin
            m_streak = 0;
            e_state  = 2;
         end
         2: begin
            if (done[m_owner] || !req[m_owner]) rel = 1;
            else if (!ready) begin
               m_streak++;
               if (m_streak >= TO) begin
                  rel    = 1;
                  e_terr = 1;
               end
            end else m_streak = 0;
            if (rel) begin
               e_grant = 0; e_msel = 0; e_ssel = 0; e_state = 3;
            end
         end
         default: begin
            m_ptr   = (m_owner + 1) % NM;
            m_owner = -1;
            e_state = 0;
         end
      endcase
   endtask

   task automatic check_model();
      chk("model_state", int'(bus_state), e_state);
      chk("model_grant", int'(grant), e_grant);
      chk("model_master_sel", int'(master_sel), e_msel);
      chk("model_slave_sel", int'(slave_sel), e_ssel);
      chk("model_reject", int'(reject), e_rej);
      chk("model_timeout_err", int'(timeout_err), e_terr);
   endtask

   task automatic step(input logic [1:0] r, input logic [3:0] s, input logic [1:0] d, input logic rd);
      @(negedge clk);
      req = r; slave_id = s; done = d; ready = rd;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      req = '0; done = '0; ready = 1'b1; slave_id = '0;
      rstN = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      chk("reset_state", int'(bus_state), 0);
      chk("reset_grant", int'(grant), 0);
      chk("reset_outputs", int'({master_sel, slave_sel, reject, timeout_err}), 0);
   endtask

   typedef struct {
      logic [1:0] req;
      logic [3:0] sid;
      logic [1:0] done;
      logic       rdy;
      logic [1:0] grant;
      int         state;
      logic [1:0] ssel;
      logic [1:0] rej;
   } vec_t;

   vec_t tbl [14];
   int   seq [6];
   int   exp_seq [6];
   int   n;
   int   own;
   logic [1:0] rq;

   initial begin
      tbl[0]  = '{2'b01, 4'b0010, 2'b00, 1'b1, 2'b01, 1, 2'd2, 2'b00};
      tbl[1]  = '{2'b01, 4'b0010, 2'b00, 1'b1, 2'b01, 2, 2'd2, 2'b00};
      tbl[2]  = '{2'b01, 4'b0010, 2'b00, 1'b1, 2'b01, 2, 2'd2, 2'b00};
      tbl[3]  = '{2'b01, 4'b0010, 2'b01, 1'b1, 2'b00, 3, 2'd0, 2'b00};
      tbl[4]  = '{2'b00, 4'b0010, 2'b00, 1'b1, 2'b00, 0, 2'd0, 2'b00};
      tbl[5]  = '{2'b11, 4'b1101, 2'b00, 1'b1, 2'b01, 1, 2'd1, 2'b10};
      tbl[6]  = '{2'b11, 4'b1101, 2'b00, 1'b1, 2'b01, 2, 2'd1, 2'b00};
      tbl[7]  = '{2'b11, 4'b1101, 2'b00, 1'b1, 2'b01, 2, 2'd1, 2'b00};
      tbl[8]  = '{2'b11, 4'b1101, 2'b01, 1'b1, 2'b00, 3, 2'd0, 2'b00};
      tbl[9]  = '{2'b11, 4'b1101, 2'b00, 1'b1, 2'b00, 0, 2'd0, 2'b00};
      tbl[10] = '{2'b11, 4'b1101, 2'b00, 1'b1, 2'b01, 1, 2'd1, 2'b10};
      tbl[11] = '{2'b00, 4'b1101, 2'b00, 1'b1, 2'b01, 2, 2'd1, 2'b00};
      tbl[12] = '{2'b00, 4'b1101, 2'b00, 1'b1, 2'b00, 3, 2'd0, 2'b00};
      tbl[13] = '{2'b00, 4'b1101, 2'b00, 1'b1, 2'b00, 0, 2'd0, 2'b00};
      exp_seq = '{0, 1, 0, 1, 0, 1};

      // Vector table: single request, invalid id rejection, abort.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].req, tbl[i].sid, tbl[i].done, tbl[i].rdy);
         chk($sformatf("vec%0d_grant", i), int'(grant), int'(tbl[i].grant));
         chk($sformatf("vec%0d_state", i), int'(bus_state), tbl[i].state);
         chk($sformatf("vec%0d_slave_sel", i), int'(slave_sel), int'(tbl[i].ssel));
         chk($sformatf("vec%0d_reject", i), int'(reject), int'(tbl[i].rej));
      end

      // Simultaneous requests: master 0 first, master 1 two cycles after RELEASE.
      do_reset();
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      chk("simul_first_grant", int'(grant), 1);
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      step(2'b11, 4'b0000, 2'b01, 1'b1);
      chk("simul_release", int'(bus_state), 3);
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      chk("simul_second_grant", int'(grant), 2);
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      step(2'b11, 4'b0000, 2'b10, 1'b1);
      step(2'b00, 4'b0000, 2'b00, 1'b1);
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      chk("simul_ptr_wrap", int'(grant), 1);

      // Fairness: both requesting continuously, done 4 cycles into each BUSY.
      do_reset();
      for (int t = 0; t < 6; t++) begin
         n = 0;
         while (bus_state != 3'd1 && n < 10) begin
            step(2'b11, 4'b0000, 2'b00, 1'b1);
            n++;
         end
         chk("fair_grant_wait", (n < 10) ? 1 : 0, 1);
         seq[t] = int'(master_sel);
         rq     = grant;
         for (int k = 0; k < 4; k++) step(2'b11, 4'b0000, 2'b00, 1'b1);
         step(2'b11, 4'b0000, rq, 1'b1);
      end
      for (int t = 0; t < 6; t++) chk($sformatf("fair_seq%0d", t), seq[t], exp_seq[t]);

      // Watchdog: ready held low from BUSY entry.
      do_reset();
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      n = 0;
      while (bus_state != 3'd3 && n < 40) begin
         step(2'b01, 4'b0000, 2'b00, 1'b0);
         n++;
      end
      chk("wd_cycles", n, 16);
      chk("wd_timeout_err", int'(timeout_err), 1);
      step(2'b00, 4'b0000, 2'b00, 1'b1);
      chk("wd_err_one_cycle", int'(timeout_err), 0);

      // Watchdog restart: one ready=1 ten cycles in.
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      n = 0;
      while (bus_state != 3'd3 && n < 60) begin
         step(2'b01, 4'b0000, 2'b00, (n == 9) ? 1'b1 : 1'b0);
         n++;
      end
      chk("wd_restart_cycles", n, 26);
      chk("wd_restart_err", int'(timeout_err), 1);
      step(2'b00, 4'b0000, 2'b00, 1'b1);

      // Done coincident with expiry: done wins.
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      step(2'b01, 4'b0000, 2'b00, 1'b0);
      for (int k = 0; k < 15; k++) step(2'b01, 4'b0000, 2'b00, 1'b0);
      chk("wd_pre_expiry_busy", int'(bus_state), 2);
      step(2'b01, 4'b0000, 2'b01, 1'b0);
      chk("wd_done_wins_state", int'(bus_state), 3);
      chk("wd_done_wins_err", int'(timeout_err), 0);
      step(2'b00, 4'b0000, 2'b00, 1'b1);

      // Reset mid-BUSY with master 1 owning and pointer at 1.
      do_reset();
      step(2'b01, 4'b0010, 2'b00, 1'b1);
      step(2'b01, 4'b0010, 2'b00, 1'b1);
      step(2'b01, 4'b0010, 2'b01, 1'b1);
      step(2'b00, 4'b0010, 2'b00, 1'b1);
      step(2'b10, 4'b0100, 2'b00, 1'b1);
      step(2'b10, 4'b0100, 2'b00, 0);
      chk("rst_mid_pre_busy", int'(bus_state), 2);
      @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      chk("rst_mid_grant", int'(grant), 0);
      chk("rst_mid_sel", int'({master_sel, slave_sel}), 0);
      chk("rst_mid_state", int'(bus_state), 0);
      chk("rst_mid_terr", int'(timeout_err), 0);
      model_reset();
      @(negedge clk);
      rstN = 1'b1;
      req = '0;
      step(2'b11, 4'b0000, 2'b00, 1'b1);
      chk("rst_mid_ptr_zero", int'(grant), 1);

      // Randomized traffic against the model.
      do_reset();
      begin
         logic [1:0] r_req;
         logic [3:0] r_sid;
         logic       low_mode;
         r_req    = 2'b00;
         r_sid    = 4'b0000;
         low_mode = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NM; b++)
               if ($urandom_range(0, 15) == 0) r_req[b] = ~r_req[b];
            if ($urandom_range(0, 7) == 0) r_sid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) low_mode = ~low_mode;
            step(r_req, r_sid,
                 2'($urandom_range(0, 31) == 0 ? $urandom_range(1, 3) : 0),
                 low_mode ? 1'b0 : ($urandom_range(0, 3) != 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global time limit reached");
   end

endmodule

`default_nettype wire

// File: doc/serial_bus_scheduler.md
Name: serial_bus_scheduler

Overview:
- Round-robin grant scheduler for the shared serial bus.
- Sits between the per-master port decoders and the bus multiplexers.
- Takes decoded requests (target slave id, done) from each master port and grants the bus to one master at a time.
- Drives the slave/master select indices, and force-releases a stalled transaction via a ready-inactivity watchdog.

Parameters:
- NO_MASTERS, 2, number of requesting master ports.
- NO_SLAVES, 3, number of slaves; valid slave ids are 0..NO_SLAVES-1.
- SID_W, 2, slave id width; must satisfy 2**SID_W >= NO_SLAVES.
- TIMEOUT, 1024, BUSY cycles with ready low before forced release; must be >= 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstN  in  1  asynchronous active-low reset.
- req  in  NO_MASTERS  per-master request, level, held until granted or done.
- slave_id  in  NO_MASTERS x SID_W  per-master requested slave id, valid while req high.
- done  in  NO_MASTERS  per-master end-of-transaction pulse.
- ready  in  1  selected slave ready/activity strobe.
- grant  out  NO_MASTERS  one-hot owner, held GRANT through BUSY.
- master_sel  out  $clog2(NO_MASTERS)  owner index for bus muxes.
- slave_sel  out  SID_W  latched slave id of owner.
- reject  out  NO_MASTERS  1-cycle pulse, request refused (invalid slave id).
- timeout_err  out  1  1-cycle pulse on watchdog release.
- bus_state  out  3  current FSM state encoding.

Behaviour:
- Reset: async on rstN low. All outputs 0, FSM IDLE, rr pointer 0, watchdog 0.
- Valid request: req[m]=1 and slave_id[m] < NO_SLAVES.
- States and encoding: IDLE=0, GRANT=1, BUSY=2, RELEASE=3.
- IDLE:
  - Any req with an invalid id: reject[m] pulses the next cycle, for every invalid requester simultaneously.
  - If any valid req: pick the first valid requester starting at rr pointer and wrapping modulo NO_MASTERS.
  - Register grant, master_sel and slave_sel; go to GRANT.
  - Req high to grant high is 1 cycle.
- GRANT: one cycle; grant/sel already stable; watchdog cleared; go to BUSY.
- BUSY:
  - Watchdog increments each cycle ready=0 and clears when ready=1.
  - done[owner]=1 -> RELEASE.
  - req[owner]=0 without done is an abort -> RELEASE, no error.
  - Watchdog reaches TIMEOUT-1 with ready=0 -> RELEASE and timeout_err pulse, coincident with the RELEASE cycle.
  - done and timeout in the same cycle: done wins, no timeout_err.
  - done/req from non-owners are ignored; non-owner requests wait.
- RELEASE:
  - grant, master_sel and slave_sel return to 0.
  - rr pointer = (owner+1) mod NO_MASTERS; go to IDLE.
- Minimum gap between consecutive grants is 2 cycles (RELEASE, IDLE).
- slave_id changes during BUSY do not affect slave_sel.
- reject never asserts for a master currently owning the bus.
- Reset mid-transaction: immediate clear, no timeout_err, no release pulse.

Decomposition:
- Package serial_bus_pkg:
  - typedef enum logic [2:0] bus_state_t {IDLE, GRANT, BUSY, RELEASE}.
  - Localparam helpers for index widths.
  - The same 3-bit encoding exported for other bus_state consumers.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: valid request vector, pointer.
  - Outputs: one-hot winner and index.
- The scheduler holds the FSM, the pointer, latched selects and the watchdog.

Test Plan:
- Single request: reset, req[0]=1, slave_id[0]=2.
  - grant=01, slave_sel=2, bus_state=1 one cycle later, then 2.
  - done[0] pulse -> bus_state=3 then 0, grant=00.
- Simultaneous requests after reset: req=11.
  - Master 0 granted first.
  - After its done, master 1 granted 2 cycles after RELEASE.
  - Pointer ends at 0.
- Fairness: req=11 held, done pulsed 4 cycles into each BUSY for 6 transactions.
  - Grant sequence 0,1,0,1,0,1.
  - No master granted twice consecutively.
- Watchdog: TIMEOUT=16, granted master, ready held 0.
  - timeout_err pulses on the cycle bus_state=3, 16 cycles after BUSY entry.
  - A single ready=1 at cycle 10 restarts the count.
  - done coincident with expiry -> no timeout_err.
- Invalid id: NO_SLAVES=3, req[1]=1 with slave_id=3, req[0]=1 with slave_id=1.
  - reject=10 for one cycle; grant=01, slave_sel=1; master 1 never granted.
- Reset mid-BUSY: rstN low asynchronously.
  - grant, sel, bus_state and timeout_err at 0 before the next clock edge.
  - After release, the pointer restarts at 0.
